// File: rtl/onehot_seq_pkg.sv
// rtl/onehot_seq_pkg.sv - state indices, one-hot state constants and fill-width helper for onehot_seq_detector
package onehot_seq_pkg;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;

    localparam logic [2:0] ST_IDLE = 3'b001 << S_IDLE;
    localparam logic [2:0] ST_LOAD = 3'b001 << S_LOAD;
    localparam logic [2:0] ST_RUN  = 3'b001 << S_RUN;

    // Fill counter must reach PAT_W exactly and saturate there.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/onehot_seq_chan.sv
// rtl/onehot_seq_chan.sv - one serial channel: history shift register, fill count, det pulse, optional hit counter
// Hit counter present only when ONEHOT_HIT_CNT_EN is defined.
module onehot_seq_chan
    import onehot_seq_pkg::*;
#(
    parameter int PAT_W   = 4,
    parameter int OVERLAP = 1
`ifdef ONEHOT_HIT_CNT_EN
    ,
    parameter int CNT_W   = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             flush,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             det
`ifdef ONEHOT_HIT_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_n;
    logic              sample;
    logic              hit;

    always_comb begin
        hist_n = {hist[PAT_W-2:0], in_bit};
        fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        sample = run && !flush && !clear && in_valid;
        hit    = sample && (hist_n == pattern) && (fill_n == FILL_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            det  <= 1'b0;
        end else if (flush || clear) begin
            hist <= '0;
            fill <= '0;
            det  <= 1'b0;
        end else begin
            det <= hit;
            if (sample) begin
                hist <= hist_n;
                // Non-overlapping mode: a match consumes its bits.
                fill <= (hit && (OVERLAP == 0)) ? '0 : fill_n;
            end
        end
    end

`ifdef ONEHOT_HIT_CNT_EN
    // Cleared on LOAD only; clear leaves the running totals intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (flush) begin
            hit_cnt <= '0;
        end else if (hit && (hit_cnt != {CNT_W{1'b1}})) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/onehot_seq_detector.sv
// rtl/onehot_seq_detector.sv - multi-channel serial pattern detector with one-hot IDLE/LOAD/RUN control FSM
// Per-channel hit counters and the hit_cnt port exist only when ONEHOT_HIT_CNT_EN is defined.
module onehot_seq_detector
    import onehot_seq_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int PAT_W   = 4,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_load,
    input  logic [PAT_W-1:0]        cfg_pattern,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_bit,
    output logic [NUM_CH-1:0]       det,
    output logic [2:0]              state_oh
`ifdef ONEHOT_HIT_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] hit_cnt
`endif
);

    if (PAT_W < 2 || CNT_W < 1) begin : g_bad_params
        $error("onehot_seq_detector: PAT_W must be >= 2 and CNT_W >= 1");
    end

    logic [2:0]       state_n;
    logic [PAT_W-1:0] pattern;
    logic             run;
    logic             flush;

    // clear overrides everything; any non-one-hot value falls back to IDLE.
    always_comb begin
        state_n = ST_IDLE;
        if (!clear) begin
            case (state_oh)
                ST_IDLE: state_n = cfg_load ? ST_LOAD : ST_IDLE;
                ST_LOAD: state_n = ST_RUN;
                ST_RUN:  state_n = cfg_load ? ST_LOAD : ST_RUN;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_oh <= ST_IDLE;
            pattern  <= '0;
        end else begin
            state_oh <= state_n;
            if (state_n == ST_LOAD) begin
                pattern <= cfg_pattern;
            end
        end
    end

    always_comb begin
        run   = (state_oh == ST_RUN);
        flush = (state_oh == ST_LOAD);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        onehot_seq_chan #(
            .PAT_W   (PAT_W),
            .OVERLAP (OVERLAP)
`ifdef ONEHOT_HIT_CNT_EN
            ,
            .CNT_W   (CNT_W)
`endif
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .run      (run),
            .flush    (flush),
            .clear    (clear),
            .pattern  (pattern),
            .in_valid (in_valid[c]),
            .in_bit   (in_bit[c]),
            .det      (det[c])
`ifdef ONEHOT_HIT_CNT_EN
            ,
            .hit_cnt  (hit_cnt[c*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_onehot_seq_detector.sv
// tb/tb_onehot_seq_detector.sv - scoreboard bench for onehot_seq_detector (overlap and non-overlap instances; ONEHOT_HIT_CNT_EN aware)
`timescale 1ns/1ps
module tb_onehot_seq_detector;

    localparam int NUM_CH = 2;
    localparam int PAT_W  = 4;
    localparam int CNT_A  = 8;
    localparam int CNT_B  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_load;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              clear;
    logic [NUM_CH-1:0] in_valid;
    logic [NUM_CH-1:0] in_bit;
    logic [NUM_CH-1:0] det_a;
    logic [NUM_CH-1:0] det_b;
    logic [2:0]        st_a;
    logic [2:0]        st_b;
`ifdef ONEHOT_HIT_CNT_EN
    logic [NUM_CH*CNT_A-1:0] cnt_a;
    logic [NUM_CH*CNT_B-1:0] cnt_b;
`endif

    always #5 clk = ~clk;

    onehot_seq_detector #(.NUM_CH(NUM_CH), .PAT_W(PAT_W), .OVERLAP(1), .CNT_W(CNT_A)) dut_a (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .clear(clear),
        .in_valid(in_valid), .in_bit(in_bit), .det(det_a), .state_oh(st_a)
`ifdef ONEHOT_HIT_CNT_EN
        , .hit_cnt(cnt_a)
`endif
    );

    onehot_seq_detector #(.NUM_CH(NUM_CH), .PAT_W(PAT_W), .OVERLAP(0), .CNT_W(CNT_B)) dut_b (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .clear(clear),
        .in_valid(in_valid), .in_bit(in_bit), .det(det_b), .state_oh(st_b)
`ifdef ONEHOT_HIT_CNT_EN
        , .hit_cnt(cnt_b)
`endif
    );

    typedef struct packed {
        logic [NUM_CH-1:0]       det_a;
        logic [NUM_CH-1:0]       det_b;
        logic [2:0]              st;
        logic [NUM_CH*CNT_A-1:0] h_a;
        logic [NUM_CH*CNT_B-1:0] h_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulses_a[NUM_CH];
    int   pulses_b[NUM_CH];

    // Reference model: 0 idle, 1 load, 2 run; histories are bit lists since the last restart.
    int               mode;
    logic [PAT_W-1:0] m_pat;
    bit               hist_q[2][NUM_CH][$];
    int               hits[2][NUM_CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mode  = 0;
        m_pat = '0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NUM_CH; c++) begin
                hist_q[d][c].delete();
                hits[d][c] = 0;
            end
    endtask

    task automatic drive(input bit ld, input logic [PAT_W-1:0] pat, input bit clr,
                         input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] b);
        exp_t e;
        int   val;
        bit   m;
        @(negedge clk);
        cfg_load = ld;
        if (ld) cfg_pattern = pat;
        clear    = clr;
        in_valid = v;
        in_bit   = b;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m = 1'b0;
                if (mode == 1) hits[d][c] = 0;
                if (clr || mode == 1) begin
                    hist_q[d][c].delete();
                end else if (mode == 2 && v[c]) begin
                    hist_q[d][c].push_back(b[c]);
                    if (hist_q[d][c].size() > PAT_W) void'(hist_q[d][c].pop_front());
                    val = 0;
                    for (int i = 0; i < hist_q[d][c].size(); i++) val = val * 2 + int'(hist_q[d][c][i]);
                    if (hist_q[d][c].size() == PAT_W && val == int'(m_pat)) begin
                        m = 1'b1;
                        if (d == 1) hist_q[d][c].delete();
                        if (hits[d][c] < (1 << (d == 0 ? CNT_A : CNT_B)) - 1) hits[d][c]++;
                    end
                end
                if (d == 0) begin
                    e.det_a[c] = m;
                    e.h_a[c*CNT_A +: CNT_A] = CNT_A'(hits[0][c]);
                end else begin
                    e.det_b[c] = m;
                    e.h_b[c*CNT_B +: CNT_B] = CNT_B'(hits[1][c]);
                end
            end
        end
        if (clr) mode = 0;
        else if (mode == 1) mode = 2;
        else if (ld) begin
            mode  = 1;
            m_pat = pat;
        end
        e.st = 3'b001 << mode;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic zero_pulses();
        for (int c = 0; c < NUM_CH; c++) begin
            pulses_a[c] = 0;
            pulses_b[c] = 0;
        end
    endtask

    task automatic load(input logic [PAT_W-1:0] pat);
        drive(1'b1, pat, 1'b0, '0, '0);
        drive(1'b0, pat, 1'b0, '0, '0);
    endtask

    // Monitor: compare every clocked response against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst == 1'b0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("det_a", 64'(det_a), 64'(e.det_a));
                check("det_b", 64'(det_b), 64'(e.det_b));
                check("state_a", 64'(st_a), 64'(e.st));
                check("state_b", 64'(st_b), 64'(e.st));
`ifdef ONEHOT_HIT_CNT_EN
                check("hit_cnt_a", 64'(cnt_a), 64'(e.h_a));
                check("hit_cnt_b", 64'(cnt_b), 64'(e.h_b));
`endif
                for (int c = 0; c < NUM_CH; c++) begin
                    if (det_a[c]) pulses_a[c]++;
                    if (det_b[c]) pulses_b[c]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PAT_W-1:0] s1011;
        logic [6:0]       stream;
        logic [3:0]       gap_bits;
        s1011 = 4'b1011;
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; clear = 1'b0; in_valid = '0; in_bit = '0;
        model_reset();
        zero_pulses();
        #12;
        check("reset_state_a", 64'(st_a), 64'd1);
        check("reset_state_b", 64'(st_b), 64'd1);
        check("reset_det", 64'({det_a, det_b}), 64'd0);
`ifdef ONEHOT_HIT_CNT_EN
        check("reset_cnt", 64'({cnt_a, cnt_b}), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Overlap stream 1,0,1,1,0,1,1 against 1011
        load(s1011);
        stream = 7'b1011011;
        for (int i = 6; i >= 0; i--) drive(1'b0, s1011, 1'b0, 2'b01, {1'b0, stream[i]});
        wait_drain();
        check("overlap_pulses_a", 64'(pulses_a[0]), 64'd2);
        check("overlap_pulses_b", 64'(pulses_b[0]), 64'd1);

        // Eight ones against 1111, then twelve more for counter saturation
        zero_pulses();
        load(4'b1111);
        for (int i = 0; i < 8; i++) drive(1'b0, 4'b1111, 1'b0, 2'b01, 2'b01);
        wait_drain();
        check("nonoverlap_pulses_a", 64'(pulses_a[0]), 64'd5);
        check("nonoverlap_pulses_b", 64'(pulses_b[0]), 64'd2);
        for (int i = 0; i < 12; i++) drive(1'b0, 4'b1111, 1'b0, 2'b01, 2'b01);
        wait_drain();
        check("five_matches_b", 64'(pulses_b[0]), 64'd5);
`ifdef ONEHOT_HIT_CNT_EN
        check("hit_cnt_saturated", 64'(cnt_b[CNT_B-1:0]), 64'd3);
        load(4'b1111);
        wait_drain();
        check("hit_cnt_load_clear", 64'(cnt_b[CNT_B-1:0]), 64'd0);
`endif

        // Gapped ch1 stream 1,0,1,1 with random ch0 traffic
        zero_pulses();
        load(s1011);
        gap_bits = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, s1011, 1'b0, {1'b1, 1'($urandom)}, {gap_bits[i], 1'($urandom)});
            drive(1'b0, s1011, 1'b0, {1'b0, 1'($urandom)}, 2'($urandom));
        end
        wait_drain();
        check("gap_pulses_a1", 64'(pulses_a[1]), 64'd1);
        check("gap_pulses_b1", 64'(pulses_b[1]), 64'd1);

        // cfg_load mid-pattern restarts detection; cfg_load+clear goes IDLE
        zero_pulses();
        load(s1011);
        drive(1'b0, s1011, 1'b0, 2'b01, 2'b01);
        drive(1'b0, s1011, 1'b0, 2'b01, 2'b00);
        drive(1'b0, s1011, 1'b0, 2'b01, 2'b01);
        drive(1'b1, s1011, 1'b0, 2'b00, 2'b00);
        drive(1'b0, s1011, 1'b0, 2'b01, 2'b01);
        drive(1'b0, s1011, 1'b0, 2'b01, 2'b01);
        drive(1'b1, s1011, 1'b1, 2'b00, 2'b00);
        wait_drain();
        check("reload_no_match", 64'(pulses_a[0]), 64'd0);
        check("load_clear_idle", 64'(st_a), 64'd1);

        // Randomised traffic with occasional reload / clear
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 39) == 0, 4'($urandom), $urandom_range(0, 79) == 0,
                  2'($urandom), 2'($urandom));
        end
        wait_drain();

        // Asynchronous reset right after a completing sample on both channels
        load(s1011);
        for (int i = 3; i >= 0; i--) drive(1'b0, s1011, 1'b0, 2'b11, {2{s1011[i]}});
        @(posedge clk);
        #3;
        check("pre_reset_det", 64'(det_a), 64'd3);
        rst = 1'b1; cfg_load = 1'b0; clear = 1'b0; in_valid = '0; in_bit = '0;
        #1;
        check("async_state", 64'(st_a), 64'd1);
        check("async_det", 64'({det_a, det_b}), 64'd0);
`ifdef ONEHOT_HIT_CNT_EN
        check("async_cnt", 64'({cnt_a, cnt_b}), 64'd0);
`endif
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        load(s1011);
        for (int i = 0; i < 8; i++) drive(1'b0, s1011, 1'b0, 2'($urandom), 2'($urandom));
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
